// File: rtl/param_divider.sv
// Programmable clock-enable divider: square wave plus period-start strobe.
// New settings are staged and only take effect at a period boundary.
module param_divider #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned RST_DIV = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] div,
  input  logic [WIDTH-1:0] duty,
  input  logic             sym,
  output logic             out,
  output logic             tick,
  output logic             busy
);

  typedef struct packed {
    logic [WIDTH-1:0] div;
    logic [WIDTH-1:0] duty;
    logic             sym;
  } cfg_t;

  localparam logic [WIDTH-1:0] RST_D = WIDTH'(RST_DIV);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH:0]   ONE_X = (WIDTH+1)'(1);
  localparam cfg_t RST_CFG = {RST_D, {WIDTH{1'b0}}, 1'b1};

  cfg_t             act_q, act_d;
  cfg_t             pnd_q, pnd_d;
  cfg_t             in_cfg;
  logic             p_vld_q, p_vld_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             bnd;
  logic             out_d, tick_d;
  logic [WIDTH:0]   per, high, low_len;
  logic [WIDTH:0]   duty_x, cnt_x;

  assign in_cfg = {div, duty, sym};
  assign bnd    = en && (cnt_q == act_q.div);
  assign busy   = p_vld_q;

  always_comb begin
    act_d   = act_q;
    pnd_d   = pnd_q;
    p_vld_d = p_vld_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    unique case (1'b1)
      bnd && load: begin
        act_d   = in_cfg;
        p_vld_d = 1'b0;
      end
      bnd && !load && p_vld_q: begin
        act_d   = pnd_q;
        p_vld_d = 1'b0;
      end
      !bnd && load: begin
        pnd_d   = in_cfg;
        p_vld_d = 1'b1;
      end
      default: ;
    endcase
    if (en) begin
      cnt_d  = bnd ? '0 : cnt_q + ONE;
      tick_d = bnd;
    end
  end

  // Output for the next cycle uses the settings that will be active then.
  always_comb begin
    per     = {1'b0, act_d.div} + ONE_X;
    duty_x  = {1'b0, act_d.duty};
    cnt_x   = {1'b0, cnt_d};
    high    = '0;
    if (act_d.sym) begin
      high = per >> 1;
    end else begin
      high = (duty_x < per) ? duty_x : per;
    end
    low_len = per - high;
    out_d   = en ? (cnt_x >= low_len) : out;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_q   <= RST_CFG;
      pnd_q   <= '0;
      p_vld_q <= 1'b0;
      cnt_q   <= RST_D;
      out     <= 1'b0;
      tick    <= 1'b0;
    end else begin
      act_q   <= act_d;
      pnd_q   <= pnd_d;
      p_vld_q <= p_vld_d;
      cnt_q   <= cnt_d;
      out     <= out_d;
      tick    <= tick_d;
    end
  end

endmodule

// File: tb/tb_param_divider.sv
// Directed bench for param_divider: per-cycle out/tick/busy patterns.
// Pattern bit i holds the expected value after the i-th edge of a run.
module tb_param_divider;

  logic       clk;
  logic       reset;
  logic       en;
  logic       load;
  logic [7:0] div;
  logic [7:0] duty;
  logic       sym;
  logic       out;
  logic       tick;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  param_divider #(
    .WIDTH  (8),
    .RST_DIV(1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .load (load),
    .div  (div),
    .duty (duty),
    .sym  (sym),
    .out  (out),
    .tick (tick),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got,
                     input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic seq(input string tag, input int n,
                     input logic [31:0] op,
                     input logic [31:0] tp,
                     input logic [31:0] bp);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      load = 1'b0;
      chk($sformatf("%s.out[%0d]", tag, i), out, op[i]);
      chk($sformatf("%s.tick[%0d]", tag, i), tick, tp[i]);
      chk($sformatf("%s.busy[%0d]", tag, i), busy, bp[i]);
    end
  endtask

  task automatic stage(input logic [7:0] d, input logic [7:0] u,
                       input logic s);
    load = 1'b1;
    div  = d;
    duty = u;
    sym  = s;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    load  = 1'b0;
    div   = '0;
    duty  = '0;
    sym   = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("rst.out", out, 1'b0);
    chk("rst.tick", tick, 1'b0);
    chk("rst.busy", busy, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    en    = 1'b1;

    seq("rdiv", 5, 32'b01010, 32'b10101, 32'b0);

    stage(8'd4, 8'd0, 1'b1);
    seq("d4", 11, 32'b11000110001, 32'b00001000010, 32'b1);

    stage(8'd5, 8'd0, 1'b1);
    seq("d5", 12, 32'b111000111000, 32'b000001000001, 32'b0);

    stage(8'd9, 8'd3, 1'b0);
    seq("du3", 20, 32'b11100000001110000000,
        32'b00000000010000000001, 32'b0);

    stage(8'd9, 8'd0, 1'b0);
    seq("du0", 10, 32'b0, 32'b1, 32'b0);

    stage(8'd9, 8'd12, 1'b0);
    seq("du12", 10, 32'b1111111111, 32'b1, 32'b0);

    stage(8'd0, 8'd1, 1'b0);
    seq("p1d", 4, 32'b1111, 32'b1111, 32'b0);

    stage(8'd0, 8'd0, 1'b1);
    seq("p1s", 3, 32'b000, 32'b111, 32'b0);

    stage(8'd7, 8'd0, 1'b1);
    seq("d7", 4, 32'b0000, 32'b0001, 32'b0);

    stage(8'd2, 8'd0, 1'b1);
    seq("mid1", 2, 32'b11, 32'b00, 32'b11);
    stage(8'd1, 8'd0, 1'b1);
    seq("mid2", 6, 32'b101011, 32'b010100, 32'b000011);

    stage(8'd7, 8'd0, 1'b1);
    seq("bload", 4, 32'b0000, 32'b0001, 32'b0000);

    en = 1'b0;
    seq("frz1", 5, 32'b0, 32'b0, 32'b0);
    en = 1'b1;
    seq("res1", 2, 32'b11, 32'b00, 32'b0);
    en = 1'b0;
    seq("frz2", 3, 32'b111, 32'b000, 32'b0);
    en = 1'b1;
    seq("res2", 3, 32'b011, 32'b100, 32'b0);

    en = 1'b0;
    stage(8'd1, 8'd0, 1'b1);
    seq("dload", 1, 32'b0, 32'b0, 32'b1);
    en = 1'b1;
    seq("dapp", 8, 32'b01111000, 32'b10000000, 32'b01111111);
    seq("d1", 2, 32'b01, 32'b10, 32'b0);

    stage(8'd4, 8'd0, 1'b1);
    seq("pre", 1, 32'b1, 32'b0, 32'b1);
    #2 reset = 1'b0;
    #1;
    chk("arst.out", out, 1'b0);
    chk("arst.tick", tick, 1'b0);
    chk("arst.busy", busy, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    seq("post", 6, 32'b101010, 32'b010101, 32'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
